// File: rtl/sd_block_arbiter.sv
// sd_block_arbiter: round-robin serialiser of per-channel SD block requests onto the hps_io
// sd_rd/sd_wr/sd_ack handshake. Optional watchdog abort enabled by defining SD_ARB_TIMEOUT_EN.

module sd_block_arbiter #(
  parameter int NUM_CH    = 3,
  parameter int LBA_W     = 32,
  parameter int TIMEOUT_W = 24
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       req_rd,
  input  logic [NUM_CH-1:0]       req_wr,
  input  logic [NUM_CH*LBA_W-1:0] req_lba,
  input  logic [NUM_CH-1:0]       sd_ack,
  output logic [NUM_CH-1:0]       sd_rd,
  output logic [NUM_CH-1:0]       sd_wr,
  output logic [NUM_CH*LBA_W-1:0] sd_lba,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       err,
  output logic [2:0]              active_ch
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (NUM_CH < 1 || NUM_CH > 8 || LBA_W < 1 || TIMEOUT_W < 1) begin : g_param_check
    $error("sd_block_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t            state, state_next;
  logic [NUM_CH-1:0] pend_rd, pend_wr, ack_q;
  logic [LBA_W-1:0]  pend_lba [NUM_CH];
  logic [CH_W-1:0]   cur_ch, ptr, pick_ch;
  logic              pick_valid, served_wr;
  logic              ack_rise, ack_fall, tmo_hit;
  logic              grant, abort, xfer_done;
  logic [NUM_CH-1:0] cur_oh, pick_oh, clr_rd, clr_wr;
  logic [NUM_CH-1:0] pend_rd_next, pend_wr_next;
  logic [NUM_CH-1:0] sd_rd_next, sd_wr_next, busy_next, done_next, err_next;

  function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] c);
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = (c == CH_W'(i));
    return v;
  endfunction

  // Round-robin scan starts just after the last served channel; ptr itself is checked last.
  always_comb begin
    int              idx;
    logic [CH_W-1:0] cand;
    pick_valid = 1'b0;
    pick_ch    = '0;
    idx        = 0;
    cand       = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = CH_W'(idx);
      if (!pick_valid && (pend_rd[cand] || pend_wr[cand])) begin
        pick_valid = 1'b1;
        pick_ch    = cand;
      end
    end
  end

  // Edges are judged against the ack sampled last cycle, so an ack already high at grant is no rise.
  assign ack_rise = sd_ack[cur_ch] & ~ack_q[cur_ch];
  assign ack_fall = ~sd_ack[cur_ch] & ack_q[cur_ch];

`ifdef SD_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;

  always_ff @(posedge clk_sys) begin
    if (reset || state_next != state) tmo_cnt <= '0;
    else if (state != IDLE)           tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state != IDLE) && (&tmo_cnt);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (pick_valid) state_next = REQ;
      REQ: begin
        if (ack_rise)     state_next = XFER;
        else if (tmo_hit) state_next = IDLE;
      end
      XFER: begin
        if (ack_fall)     state_next = IDLE;
        else if (tmo_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The served pending bit is only cleared in REQ; requests arriving later stay queued as new work.
  always_comb begin
    grant     = (state == IDLE) && pick_valid;
    xfer_done = (state == XFER) && ack_fall;
    abort     = tmo_hit && (((state == REQ) && !ack_rise) || ((state == XFER) && !ack_fall));
    cur_oh    = onehot(cur_ch);
    pick_oh   = onehot(pick_ch);

    clr_rd = '0;
    clr_wr = '0;
    if ((state == REQ) && (ack_rise || abort)) begin
      if (served_wr) clr_wr = cur_oh;
      else           clr_rd = cur_oh;
    end
    pend_rd_next = (pend_rd & ~clr_rd) | req_rd;
    pend_wr_next = (pend_wr & ~clr_wr) | req_wr;

    sd_rd_next = '0;
    sd_wr_next = '0;
    if (grant) begin
      if (pend_wr[pick_ch]) sd_wr_next = pick_oh;
      else                  sd_rd_next = pick_oh;
    end else if ((state == REQ) && !ack_rise && !abort) begin
      sd_rd_next = sd_rd;
      sd_wr_next = sd_wr;
    end

    done_next = xfer_done ? cur_oh : '0;
    err_next  = abort ? cur_oh : '0;

    busy_next = pend_rd_next | pend_wr_next;
    if (grant)                   busy_next = busy_next | pick_oh;
    else if (state_next != IDLE) busy_next = busy_next | cur_oh;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pend_rd   <= '0;
      pend_wr   <= '0;
      ack_q     <= '0;
      sd_rd     <= '0;
      sd_wr     <= '0;
      sd_lba    <= '0;
      busy      <= '0;
      done      <= '0;
      err       <= '0;
      cur_ch    <= '0;
      served_wr <= 1'b0;
      ptr       <= CH_W'(NUM_CH - 1);
      for (int i = 0; i < NUM_CH; i++) pend_lba[i] <= '0;
    end else begin
      pend_rd <= pend_rd_next;
      pend_wr <= pend_wr_next;
      ack_q   <= sd_ack;
      sd_rd   <= sd_rd_next;
      sd_wr   <= sd_wr_next;
      busy    <= busy_next;
      done    <= done_next;
      err     <= err_next;
      if (grant) begin
        cur_ch    <= pick_ch;
        served_wr <= pend_wr[pick_ch];
      end
      if (xfer_done || abort) ptr <= cur_ch;
      for (int i = 0; i < NUM_CH; i++) begin
        if (req_rd[i] || req_wr[i]) pend_lba[i] <= req_lba[i*LBA_W +: LBA_W];
        if (grant && (pick_ch == CH_W'(i))) sd_lba[i*LBA_W +: LBA_W] <= pend_lba[i];
      end
    end
  end

  assign active_ch = 3'(cur_ch);

endmodule
